frog_game_ctrl: RTL and testbench
=================================

Name: frog_game_ctrl

Overview:
- Game-level sequencer for the frog movement datapath.
- Owns lives, the per-life timer, score, home count and stage selection.
- Drives the frog mover's `frogreset`, `lives`, `stage1x` and `stage2x` inputs from collision, river and home events, so that the frog moves only during active play.
- Sits between the collision/sprite-overlap logic and the frog mover; clocked once per video frame.

Parameters:
- START_LIVES, 3: lives loaded on new game (3-bit).
- TIME_LIMIT, 200: frames allowed per life (8-bit).
- DEATH_FRAMES, 30: frames spent in death animation.
- HOME_FRAMES, 20: frames spent in home celebration.
- HOMES_PER_STAGE, 5: homes needed to advance stage.
- HOME_POINTS, 50: score added per home.
- START_KEY, 16'h002C: keycode that starts a game.

Ports:
- frame_clk  in  1  frame-rate clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  16  current keyboard code; 16'h0000 means no key.
- hit_car  in  1  frog overlaps a vehicle this frame.
- in_river  in  1  frog Y is inside the river band.
- on_platform  in  1  OR of onlog/onbiglog/onfish2/onfish3.
- offscreen  in  1  frog X is outside the visible area.
- at_home  in  1  frog is inside a home slot.
- frogreset  out  1  one-frame pulse that recentres the frog.
- lives  out  3  remaining lives.
- stage1x  out  1  stage-1 play enable.
- stage2x  out  1  stage-2 play enable.
- dying  out  1  high during the death animation.
- game_over  out  1  high in GAME_OVER.
- time_left  out  8  frames remaining this life.
- score  out  16  accumulated score.
- homes  out  3  homes filled in the current stage.

Behaviour:
- All outputs are registered. Reset has priority over every other condition.
- Reset state:
  - state = IDLE, lives = START_LIVES, score = 0, homes = 0, stage = 1.
  - time_left = TIME_LIMIT.
  - frogreset, stage1x, stage2x, dying and game_over all 0.
  - armed = 0.
- stage1x = (state==PLAY && stage==1); stage2x = (state==PLAY && stage==2). These are never both 1, and both are 0 outside PLAY, which freezes the frog.
- IDLE:
  - If keycode == START_KEY: lives = START_LIVES, score = 0, homes = 0, stage = 1; next state RESPAWN.
- RESPAWN:
  - Lasts exactly 1 frame; frogreset = 1 during it.
  - time_left = TIME_LIMIT; next state PLAY.
- PLAY:
  - Each frame, time_left decrements, saturating at 0.
  - death = hit_car | (in_river & ~on_platform) | offscreen | (time_left == 0).
  - Priority is death > at_home > stay.
  - On death: lives = lives − 1 (saturating at 0), counter = 0, next state DYING. The decrement lands on the same edge the event is sampled.
  - On at_home (no death): score += HOME_POINTS, wrapping mod 2^16; homes += 1; counter = 0; next state HOME.
- DYING:
  - dying = 1; counter increments each frame.
  - When counter == DEATH_FRAMES−1: if lives == 0, go to GAME_OVER; otherwise go to RESPAWN.
- HOME:
  - counter increments each frame.
  - When counter == HOME_FRAMES−1:
    - If homes == HOMES_PER_STAGE: homes = 0 and stage toggles (1 -> 2, 2 -> 1).
    - Next state RESPAWN.
- GAME_OVER:
  - game_over = 1.
  - keycode == 0 sets armed = 1.
  - If armed && keycode == START_KEY: armed = 0 and perform the same load as IDLE start, then go to RESPAWN.
  - A key held down from gameplay therefore cannot restart the game.
- Inputs hit_car, in_river, on_platform, offscreen and at_home are ignored outside PLAY.
- frogreset is never asserted for more than 1 consecutive frame.
- Unused or illegal state encodings go to IDLE on the next edge.

Test Plan:
- Reset, then keycode = 002C for one frame -> RESPAWN with frogreset = 1 for 1 frame; next frame stage1x = 1, lives = 3, time_left = 200, then 199.
- In PLAY, pulse hit_car for 1 frame -> lives = 2 on that edge; dying = 1 for 30 frames with stage1x = 0; one frogreset pulse; stage1x = 1 again.
- in_river = 1 with on_platform = 1 -> no death; drop on_platform -> death on that edge. Repeat until lives = 0 -> game_over = 1 after 30 frames. Holding 002C does not restart; 0000 then 002C restarts with lives = 3 and score = 0.
- Let the timer expire -> death on the frame time_left reads 0; time_left reloads to 200 at RESPAWN.
- Five at_home events -> score = 250; after the 5th HOME period homes = 0, stage2x = 1 and stage1x = 0; a further 5 homes return to stage1x.
- Assert hit_car and at_home in the same frame -> death wins: score unchanged, lives decremented. Assert Reset mid-DYING -> IDLE with all reset values on the next edge.

Source files
------------

// File: rtl/frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// frog_game_ctrl
// Game-level sequencer for the frog movement datapath. It owns the lives, the
// per-life timer, the score, the home count and the stage selection. It also
// gates the frog mover so that the frog moves only during active play.
// Clocked once per video frame.
//
// Ports
//   frame_clk    in   1   frame-rate clock, rising edge active
//   Reset        in   1   synchronous active-high reset
//   keycode      in  16   current key code, 16'h0000 = no key
//   hit_car      in   1   frog overlaps a vehicle
//   in_river     in   1   frog Y is inside the river band
//   on_platform  in   1   frog rides a log or a turtle group
//   offscreen    in   1   frog X is outside the visible area
//   at_home      in   1   frog is inside a home slot
//   frogreset    out  1   one-frame recentre pulse (RESPAWN)
//   lives        out  3   remaining lives
//   stage1x      out  1   stage-1 play enable
//   stage2x      out  1   stage-2 play enable
//   dying        out  1   death animation in progress
//   game_over    out  1   game over screen
//   time_left    out  8   frames remaining this life
//   score        out 16   accumulated score
//   homes        out  3   homes filled in the current stage
// -----------------------------------------------------------------------------
module frog_game_ctrl #(
    parameter logic [2:0]  START_LIVES     = 3'd3,
    parameter logic [7:0]  TIME_LIMIT      = 8'd200,
    parameter logic [7:0]  DEATH_FRAMES    = 8'd30,
    parameter logic [7:0]  HOME_FRAMES     = 8'd20,
    parameter logic [2:0]  HOMES_PER_STAGE = 3'd5,
    parameter logic [15:0] HOME_POINTS     = 16'd50,
    parameter logic [15:0] START_KEY       = 16'h002C
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        hit_car,
    input  logic        in_river,
    input  logic        on_platform,
    input  logic        offscreen,
    input  logic        at_home,
    output logic        frogreset,
    output logic [2:0]  lives,
    output logic        stage1x,
    output logic        stage2x,
    output logic        dying,
    output logic        game_over,
    output logic [7:0]  time_left,
    output logic [15:0] score,
    output logic [2:0]  homes
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESPAWN   = 3'd1,
        S_PLAY      = 3'd2,
        S_DYING     = 3'd3,
        S_HOME      = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  lives_q,     lives_d;
    logic [7:0]  time_q,      time_d;
    logic [15:0] score_q,     score_d;
    logic [2:0]  homes_q,     homes_d;
    logic        stage2_q,    stage2_d;   // 0 = stage 1, 1 = stage 2
    logic [7:0]  cnt_q,       cnt_d;
    logic        armed_q,     armed_d;
    logic        frogreset_q, frogreset_d;
    logic        stage1x_q,   stage1x_d;
    logic        stage2x_q,   stage2x_d;
    logic        dying_q,     dying_d;
    logic        game_over_q, game_over_d;

    logic        death_s;
    logic        start_s;

    // The timer check uses the value currently displayed, so the frog dies on
    // the frame where time_left reads 0.
    assign death_s = hit_car | (in_river & ~on_platform) | offscreen |
                     (time_q == 8'd0);
    assign start_s = (keycode == START_KEY);

    // Next-state and next-output computation for the game sequencer.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        time_d   = time_q;
        score_d  = score_q;
        homes_d  = homes_q;
        stage2_d = stage2_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    lives_d  = START_LIVES;
                    score_d  = 16'd0;
                    homes_d  = 3'd0;
                    stage2_d = 1'b0;
                    state_d  = S_RESPAWN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RESPAWN: begin
                time_d  = TIME_LIMIT;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (time_q == 8'd0) begin
                    time_d = 8'd0;
                end else begin
                    time_d = time_q - 8'd1;
                end
                if (death_s) begin
                    if (lives_q == 3'd0) begin
                        lives_d = 3'd0;
                    end else begin
                        lives_d = lives_q - 3'd1;
                    end
                    cnt_d   = 8'd0;
                    state_d = S_DYING;
                end else if (at_home) begin
                    score_d = score_q + HOME_POINTS;
                    homes_d = homes_q + 3'd1;
                    cnt_d   = 8'd0;
                    state_d = S_HOME;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_DYING: begin
                if (cnt_q == (DEATH_FRAMES - 8'd1)) begin
                    if (lives_q == 3'd0) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        state_d = S_RESPAWN;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOME: begin
                if (cnt_q == (HOME_FRAMES - 8'd1)) begin
                    if (homes_q == HOMES_PER_STAGE) begin
                        homes_d  = 3'd0;
                        stage2_d = ~stage2_q;
                    end else begin
                        homes_d  = homes_q;
                    end
                    state_d = S_RESPAWN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAME_OVER: begin
                // Restart needs a key release first, so a key held from play
                // cannot fall straight through into a new game.
                if (armed_q && start_s) begin
                    armed_d  = 1'b0;
                    lives_d  = START_LIVES;
                    score_d  = 16'd0;
                    homes_d  = 3'd0;
                    stage2_d = 1'b0;
                    state_d  = S_RESPAWN;
                end else if (keycode == 16'h0000) begin
                    armed_d  = 1'b1;
                end else begin
                    armed_d  = armed_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs reflect the state being entered so they are registered
        // alongside it.
        frogreset_d = (state_d == S_RESPAWN);
        stage1x_d   = (state_d == S_PLAY) && !stage2_d;
        stage2x_d   = (state_d == S_PLAY) &&  stage2_d;
        dying_d     = (state_d == S_DYING);
        game_over_d = (state_d == S_GAME_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            lives_q     <= START_LIVES;
            time_q      <= TIME_LIMIT;
            score_q     <= 16'd0;
            homes_q     <= 3'd0;
            stage2_q    <= 1'b0;
            cnt_q       <= 8'd0;
            armed_q     <= 1'b0;
            frogreset_q <= 1'b0;
            stage1x_q   <= 1'b0;
            stage2x_q   <= 1'b0;
            dying_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            time_q      <= time_d;
            score_q     <= score_d;
            homes_q     <= homes_d;
            stage2_q    <= stage2_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            frogreset_q <= frogreset_d;
            stage1x_q   <= stage1x_d;
            stage2x_q   <= stage2x_d;
            dying_q     <= dying_d;
            game_over_q <= game_over_d;
        end
    end

    assign frogreset = frogreset_q;
    assign lives     = lives_q;
    assign stage1x   = stage1x_q;
    assign stage2x   = stage2x_q;
    assign dying     = dying_q;
    assign game_over = game_over_q;
    assign time_left = time_q;
    assign score     = score_q;
    assign homes     = homes_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_game_ctrl
// Directed scenarios followed by randomized play, with every output compared
// each frame against a behavioural model of the game rules.
// -----------------------------------------------------------------------------
module tb_frog_game_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] keycode = 16'h0000;
    logic        hit_car = 1'b0;
    logic        in_river = 1'b0;
    logic        on_platform = 1'b0;
    logic        offscreen = 1'b0;
    logic        at_home = 1'b0;
    logic        frogreset;
    logic [2:0]  lives;
    logic        stage1x;
    logic        stage2x;
    logic        dying;
    logic        game_over;
    logic [7:0]  time_left;
    logic [15:0] score;
    logic [2:0]  homes;

    int checks = 0;
    int errors = 0;

    frog_game_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .hit_car    (hit_car),
        .in_river   (in_river),
        .on_platform(on_platform),
        .offscreen  (offscreen),
        .at_home    (at_home),
        .frogreset  (frogreset),
        .lives      (lives),
        .stage1x    (stage1x),
        .stage2x    (stage2x),
        .dying      (dying),
        .game_over  (game_over),
        .time_left  (time_left),
        .score      (score),
        .homes      (homes)
    );

    always #5 frame_clk = ~frame_clk;

    // Behavioural model: a phase name plus a countdown of frames remaining.
    localparam int P_WAIT = 0, P_RECENTRE = 1, P_RUN = 2, P_DEAD = 3, P_CHEER = 4, P_OVER = 5;
    int m_phase, m_left, m_lives, m_time, m_score, m_homes, m_stage, m_armed;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic new_game();
        m_lives = 3; m_score = 0; m_homes = 0; m_stage = 1;
        m_phase = P_RECENTRE;
    endtask

    task automatic model(input bit rst, input int k, input bit hc, ir, op, os, ah);
        if (rst) begin
            m_phase = P_WAIT; m_lives = 3; m_score = 0; m_homes = 0;
            m_stage = 1; m_time = 200; m_armed = 0; m_left = 0;
        end else begin
            case (m_phase)
                P_WAIT: if (k == 16'h002C) new_game();
                P_RECENTRE: begin m_time = 200; m_phase = P_RUN; end
                P_RUN: begin
                    bit dead;
                    dead = hc || (ir && !op) || os || (m_time == 0);
                    m_time = (m_time > 0) ? m_time - 1 : 0;
                    if (dead) begin
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        m_left = 30; m_phase = P_DEAD;
                    end else if (ah) begin
                        m_score = (m_score + 50) % 65536;
                        m_homes++;
                        m_left = 20; m_phase = P_CHEER;
                    end
                end
                P_DEAD: begin
                    m_left--;
                    if (m_left == 0) m_phase = (m_lives == 0) ? P_OVER : P_RECENTRE;
                end
                P_CHEER: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_homes == 5) begin m_homes = 0; m_stage = 3 - m_stage; end
                        m_phase = P_RECENTRE;
                    end
                end
                P_OVER: begin
                    if (m_armed != 0 && k == 16'h002C) begin m_armed = 0; new_game(); end
                    else if (k == 0) m_armed = 1;
                end
                default: m_phase = P_WAIT;
            endcase
        end
    endtask

    task automatic compare_all();
        cmp("frogreset", int'(frogreset), int'(m_phase == P_RECENTRE));
        cmp("stage1x",   int'(stage1x),   int'(m_phase == P_RUN && m_stage == 1));
        cmp("stage2x",   int'(stage2x),   int'(m_phase == P_RUN && m_stage == 2));
        cmp("dying",     int'(dying),     int'(m_phase == P_DEAD));
        cmp("game_over", int'(game_over), int'(m_phase == P_OVER));
        cmp("lives",     int'(lives),     m_lives);
        cmp("time_left", int'(time_left), m_time);
        cmp("score",     int'(score),     m_score);
        cmp("homes",     int'(homes),     m_homes);
    endtask

    task automatic step(input bit rst, input logic [15:0] k, input bit hc, ir, op, os, ah);
        Reset = rst; keycode = k; hit_car = hc; in_river = ir;
        on_platform = op; offscreen = os; at_home = ah;
        @(posedge frame_clk);
        model(rst, int'(k), hc, ir, op, os, ah);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_play(input string nm);
        int n;
        n = 0;
        while (!(stage1x || stage2x) && n < 100) begin
            idle();
            n++;
        end
        cmp(nm, int'(stage1x || stage2x), 1);
    endtask

    initial begin
        // Reset state
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("rst_lives", int'(lives), 3);
        cmp("rst_time", int'(time_left), 200);
        cmp("rst_score", int'(score), 0);
        cmp("rst_gate", int'({frogreset, stage1x, stage2x, dying, game_over}), 0);

        // Start and first play frames
        step(1'b0, 16'h002C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("start_frogreset", int'(frogreset), 1);
        idle();
        cmp("play_stage1x", int'(stage1x), 1);
        cmp("play_time0", int'(time_left), 200);
        idle();
        cmp("play_time1", int'(time_left), 199);

        // Car hit: 30 dying frames, then one recentre pulse
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("hit_lives", int'(lives), 2);
        cmp("hit_dying", int'(dying), 1);
        repeat (29) idle();
        cmp("die_last", int'(dying), 1);
        idle();
        cmp("die_respawn", int'(frogreset), 1);
        idle();
        cmp("die_replay", int'(stage1x), 1);

        // River: safe on a platform, drowned without
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cmp("river_safe", int'(dying), 0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cmp("river_drown", int'(dying), 1);
        cmp("river_lives", int'(lives), 1);
        wait_play("wait_after_drown");

        // Two full stages of homes
        for (int h = 0; h < 5; h++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            wait_play("wait_home_a");
        end
        cmp("stage_a_score", int'(score), 250);
        cmp("stage_a_s2", int'(stage2x), 1);
        cmp("stage_a_s1", int'(stage1x), 0);
        cmp("stage_a_homes", int'(homes), 0);
        for (int h = 0; h < 5; h++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            wait_play("wait_home_b");
        end
        cmp("stage_b_s1", int'(stage1x), 1);
        cmp("stage_b_score", int'(score), 500);

        // Death beats home; last life leads to game over
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("prio_score", int'(score), 500);
        cmp("prio_lives", int'(lives), 0);
        repeat (30) idle();
        cmp("over_flag", int'(game_over), 1);
        repeat (5) step(1'b0, 16'h002C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("over_held_key", int'(game_over), 1);
        idle();
        step(1'b0, 16'h002C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("restart_fr", int'(frogreset), 1);
        cmp("restart_lives", int'(lives), 3);
        cmp("restart_score", int'(score), 0);

        // Timer expiry
        idle();
        repeat (200) idle();
        cmp("timer_zero", int'(time_left), 0);
        cmp("timer_zero_alive", int'(dying), 0);
        idle();
        cmp("timer_death", int'(dying), 1);
        wait_play("wait_after_timer");
        cmp("timer_reload", int'(time_left), 200);

        // Reset during the death animation
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("off_dying", int'(dying), 1);
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("mid_rst_dying", int'(dying), 0);
        cmp("mid_rst_lives", int'(lives), 3);
        cmp("mid_rst_time", int'(time_left), 200);

        // Randomized play
        for (int i = 0; i < 8000; i++) begin
            bit r;
            int ks;
            logic [15:0] k;
            r  = ($urandom_range(0, 2999) == 0);
            ks = $urandom_range(0, 9);
            if (ks < 6)      k = 16'h0000;
            else if (ks < 9) k = 16'h002C;
            else             k = 16'($urandom);
            step(r, k,
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
